// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: clears the file after reset, then arbitrates
// between core read/write traffic and single-cycle debug access slots.
module regfile_access_ctrl #(
  parameter logic [31:0] INIT_VALUE   = 32'd0,
  parameter bit          ZERO_PROTECT = 1'b1,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // core side
  input  logic [4:0]  core_rs,
  input  logic [4:0]  core_rt,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wdata,
  input  logic        core_we,
  output logic        core_stall,
  output logic        init_done,
  // debug port
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  // register file pins
  output logic [4:0]  rf_rs,
  output logic [4:0]  rf_rt,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data_in,
  output logic        rf_regwrite,
  input  logic [31:0] rf_rdata1
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(31);
  localparam logic [WW-1:0] MAX_WAIT  = WW'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   init_cnt, init_cnt_nxt;
  logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
  logic            init_done_nxt;
  logic            dbg_ack_nxt;
  logic [DW-1:0]   dbg_rdata_nxt;
  logic            regwrite_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      init_done <= 1'b0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      init_done <= init_done_nxt;
      dbg_ack   <= dbg_ack_nxt;
      dbg_rdata <= dbg_rdata_nxt;
    end
  end

  // Next-state logic and register-file pin muxing
  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    wait_cnt_nxt  = wait_cnt;
    init_done_nxt = init_done;
    dbg_ack_nxt   = 1'b0;
    dbg_rdata_nxt = dbg_rdata;
    core_stall    = 1'b1;
    rf_rs         = core_rs;
    rf_rt         = core_rt;
    rf_rd         = core_rd;
    rf_data_in    = core_wdata;
    regwrite_c    = 1'b0;

    unique case (state)
      ST_INIT: begin
        rf_rd        = init_cnt;
        rf_data_in   = INIT_VALUE;
        regwrite_c   = 1'b1;
        init_cnt_nxt = init_cnt + AW'(1);
        if (init_cnt == LAST_ADDR) begin
          state_nxt     = ST_RUN;
          init_done_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        core_stall = 1'b0;
        regwrite_c = core_we;
        // No grant in the ack cycle so a still-held request is not served twice
        if (dbg_req && !dbg_ack && (!core_we || (wait_cnt == MAX_WAIT))) begin
          state_nxt    = ST_DBG;
          wait_cnt_nxt = '0;
        end else if (dbg_req) begin
          if (wait_cnt != MAX_WAIT) begin
            wait_cnt_nxt = wait_cnt + WW'(1);
          end
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      ST_DBG: begin
        rf_rs = dbg_addr;
        if (dbg_we) begin
          rf_rd      = dbg_addr;
          rf_data_in = dbg_wdata;
          regwrite_c = 1'b1;
        end
        // Read port sees the pre-write contents this cycle
        dbg_rdata_nxt = rf_rdata1;
        dbg_ack_nxt   = 1'b1;
        state_nxt     = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase

    if (ZERO_PROTECT && (rf_rd == '0)) begin
      regwrite_c = 1'b0;
    end
  end

  // Writes are blocked for as long as reset is held
  assign rf_regwrite = regwrite_c & rst_n;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file plus a scoreboard of
// expected register contents, directed scenarios and randomized traffic.
module tb_regfile_access_ctrl;

  localparam logic [31:0] INIT_V = 32'hA5A5_A5A5;
  localparam int          MAXW   = 4;
  localparam logic [31:0] PREF   = 32'h0BAD_0000;

  logic        clk;
  logic        rst_n;
  logic [4:0]  core_rs, core_rt, core_rd;
  logic [31:0] core_wdata;
  logic        core_we;
  logic        core_stall;
  logic        init_done;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  rf_rs, rf_rt, rf_rd;
  logic [31:0] rf_data_in;
  logic        rf_regwrite;
  logic [31:0] rf_rdata1;

  regfile_access_ctrl #(
    .INIT_VALUE  (INIT_V),
    .ZERO_PROTECT(1'b1),
    .DBG_MAX_WAIT(MAXW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_rs    (core_rs),
    .core_rt    (core_rt),
    .core_rd    (core_rd),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_stall (core_stall),
    .init_done  (init_done),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
    .rf_rs      (rf_rs),
    .rf_rt      (rf_rt),
    .rf_rd      (rf_rd),
    .rf_data_in (rf_data_in),
    .rf_regwrite(rf_regwrite),
    .rf_rdata1  (rf_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file, preloaded with a known pattern
  logic [31:0] mem [32];
  logic        loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= PREF + 32'(i);
    end else if (rf_regwrite) begin
      mem[rf_rd] <= rf_data_in;
    end
  end
  assign rf_rdata1 = mem[rf_rs];

  logic [31:0] ref_rf [32];
  int n_tests, n_fail;
  int stall_cnt, ack_cnt, lat, last_lat;
  bit pend, hold_req, run_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_rf[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // One clock cycle: checks pins, advances the scoreboard, returns at the next negedge
  task automatic cycle();
    logic stl, cwe;
    logic [4:0] crd;
    logic [31:0] cwd;
    #1;
    stl = core_stall; cwe = core_we; crd = core_rd; cwd = core_wdata;
    if (run_phase) begin
      if (!stl) begin
        check("pt_rs", 32'(rf_rs), 32'(core_rs));
        check("pt_rt", 32'(rf_rt), 32'(core_rt));
        check("pt_rd", 32'(rf_rd), 32'(crd));
        check("pt_data", rf_data_in, cwd);
        check("pt_we", 32'(rf_regwrite), 32'(cwe && (crd != 5'd0)));
      end else begin
        stall_cnt++;
        if (pend) begin
          check("dbg_rs", 32'(rf_rs), 32'(dbg_addr));
          check("dbg_regwrite", 32'(rf_regwrite), 32'(dbg_we && (dbg_addr != 5'd0)));
          if (dbg_we) begin
            check("dbg_rd", 32'(rf_rd), 32'(dbg_addr));
            check("dbg_data", rf_data_in, dbg_wdata);
          end
        end
      end
    end
    @(posedge clk); #1;
    if (run_phase && !stl && cwe && (crd != 5'd0)) ref_rf[crd] = cwd;
    if (pend) lat++;
    if (dbg_ack) begin
      ack_cnt++;
      if (!pend) begin
        check("spurious_ack", 32'd1, 32'd0);
      end else begin
        check("dbg_rdata", dbg_rdata, ref_rf[dbg_addr]);
        if (dbg_we && (dbg_addr != 5'd0)) ref_rf[dbg_addr] = dbg_wdata;
        check("dbg_lat_bound", 32'(lat <= MAXW + 2), 32'd1);
        check("stall_per_access", 32'(stall_cnt), 32'(ack_cnt));
        last_lat = lat;
        pend = 1'b0;
      end
    end else if (pend && lat > MAXW + 4) begin
      check("dbg_timeout", 32'(lat), 32'(MAXW + 2));
      last_lat = -1;
      pend = 1'b0;
      hold_req = 1'b0;
    end
    @(negedge clk);
    if (!pend && !hold_req) dbg_req = 1'b0;
  endtask

  task automatic dbg_run(input logic we, input logic [4:0] a, input logic [31:0] d, output int lat_o);
    if (dbg_ack) cycle();
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    pend = 1'b1; lat = 0;
    for (int k = 0; k < 20 && pend; k++) cycle();
    lat_o = last_lat;
  endtask

  // Called at the negedge on which rst_n is released
  task automatic init_check();
    for (int i = 0; i < 32; i++) begin
      #1;
      check("init_stall", 32'(core_stall), 32'd1);
      check("init_done_low", 32'(init_done), 32'd0);
      check("init_rd", 32'(rf_rd), 32'(i));
      check("init_we", 32'(rf_regwrite), 32'(i != 0));
      if (i != 0) check("init_data", rf_data_in, INIT_V);
      check("init_no_ack", 32'(dbg_ack), 32'd0);
      @(negedge clk);
    end
    #1;
    check("init_done_high", 32'(init_done), 32'd1);
    check("run_stall_low", 32'(core_stall), 32'd0);
    check("init_no_ack_end", 32'(dbg_ack), 32'd0);
    ref_rf[0] = PREF;
    for (int i = 1; i < 32; i++) ref_rf[i] = INIT_V;
    compare_mem("init_contents");
    run_phase = 1'b1;
    stall_cnt = 0;
    ack_cnt   = 0;
  endtask

  initial begin
    int l, s0, a0;
    n_tests = 0; n_fail = 0; stall_cnt = 0; ack_cnt = 0; lat = 0; last_lat = 0;
    pend = 1'b0; hold_req = 1'b0; run_phase = 1'b0; loaded = 1'b0;
    rst_n = 1'b0; core_rs = '0; core_rt = '0; core_rd = '0; core_wdata = '0; core_we = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    repeat (2) @(posedge clk);
    loaded = 1'b1;
    @(negedge clk); #1;
    check("rst_stall", 32'(core_stall), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_regwrite", 32'(rf_regwrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    init_check();

    // Core writes pass through; address 0 is masked
    core_rd = 5'd5; core_wdata = 32'h1234; core_we = 1'b1; #1;
    check("core_we_rd5", 32'(rf_regwrite), 32'd1);
    check("core_rd5", 32'(rf_rd), 32'd5);
    cycle();
    core_rd = 5'd0; core_wdata = 32'h5555; #1;
    check("core_we_rd0", 32'(rf_regwrite), 32'd0);
    cycle();
    core_we = 1'b0;
    cycle();
    check("rf5_value", mem[5], 32'h1234);
    check("rf0_kept", mem[0], PREF);

    // Debug write then read with the core idle
    s0 = stall_cnt;
    dbg_run(1'b1, 5'd7, 32'hDEAD_BEEF, l);
    check("dbg_wr_lat", 32'(l), 32'd2);
    check("dbg_wr_stall", 32'(stall_cnt - s0), 32'd1);
    check("rf7_value", mem[7], 32'hDEAD_BEEF);
    s0 = stall_cnt;
    dbg_run(1'b0, 5'd7, 32'h0, l);
    check("dbg_rd_lat", 32'(l), 32'd2);
    check("dbg_rd_stall", 32'(stall_cnt - s0), 32'd1);
    check("dbg_rd_value", dbg_rdata, 32'hDEAD_BEEF);
    cycle();
    check("dbg_rdata_held", dbg_rdata, 32'hDEAD_BEEF);

    // Continuous core writes force a grant after the wait limit
    core_rd = 5'd3; core_wdata = 32'h33; core_we = 1'b1;
    dbg_run(1'b0, 5'd7, 32'h0, l);
    check("forced_lat", 32'(l), 32'(MAXW + 2));
    check("forced_rdata", dbg_rdata, 32'hDEAD_BEEF);
    core_we = 1'b0;
    cycle();

    // Same-address collision: core write in grant cycle, debug write lands after
    core_rd = 5'd9; core_wdata = 32'd1; core_we = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'd2;
    pend = 1'b1; lat = 0; hold_req = 1'b1; a0 = ack_cnt;
    for (int k = 0; k < MAXW + 1; k++) cycle();
    core_we = 1'b0;
    for (int k = 0; k < 6 && pend; k++) cycle();
    check("collide_acked", 32'(pend), 32'd0);
    cycle();
    hold_req = 1'b0; dbg_req = 1'b0;
    repeat (4) cycle();
    check("collide_one_ack", 32'(ack_cnt - a0), 32'd1);
    check("collide_rf9", mem[9], 32'd2);

    // Reset in the debug slot: no ack, writes blocked, clearing restarts
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hCAFE_0012;
    pend = 1'b1; lat = 0; hold_req = 1'b1;
    cycle();
    #1;
    check("in_dbg_stall", 32'(core_stall), 32'd1);
    rst_n = 1'b0; run_phase = 1'b0; #1;
    check("rstdbg_regwrite", 32'(rf_regwrite), 32'd0);
    check("rstdbg_ack", 32'(dbg_ack), 32'd0);
    check("rstdbg_stall", 32'(core_stall), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rstlow_ack", 32'(dbg_ack), 32'd0);
      check("rstlow_regwrite", 32'(rf_regwrite), 32'd0);
    end
    @(negedge clk);
    pend = 1'b0;
    rst_n = 1'b1;
    init_check();
    // The still-held request is served once clearing is done
    pend = 1'b1; lat = 0; hold_req = 1'b0;
    for (int k = 0; k < 10 && pend; k++) cycle();
    check("post_rst_lat", 32'(last_lat), 32'd2);
    check("post_rst_rf12", mem[12], 32'hCAFE_0012);

    // Randomized core and debug traffic against the scoreboard
    for (int n = 0; n < 600; n++) begin
      if (!core_stall) begin
        core_rs = 5'($urandom); core_rt = 5'($urandom); core_rd = 5'($urandom);
        core_wdata = $urandom; core_we = 1'($urandom);
      end
      if (!pend && !dbg_req && !dbg_ack && ($urandom_range(0, 5) == 0)) begin
        dbg_req = 1'b1; dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
        pend = 1'b1; lat = 0;
      end
      cycle();
      if ((n % 100) == 99) compare_mem("rand_contents");
    end
    core_we = 1'b0;
    for (int k = 0; k < 12 && pend; k++) cycle();
    cycle();
    compare_mem("final_contents");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequences and shares the 32x32 register file between the core datapath and a debug port. After reset it clears every register (32 write cycles) while stalling the core. It then passes core read/write traffic through and inserts single-cycle debug read/write slots by stalling the core. It sits between the core's decode/writeback stages and the register file's rs/rt/rd/Data_In/RegWrite pins.

## Interface
- INIT_VALUE, 32'd0, value written to every register during INIT
- ZERO_PROTECT, 1, when 1, writes (core or debug) to address 0 are suppressed
- DBG_MAX_WAIT, 4, RUN cycles a pending debug request may wait on busy core writes before a forced grant (1..15)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- core_rs, core_rt, core_rd  in  5 each  core register addresses
- core_wdata  in  32  core writeback data
- core_we  in  1  core write enable
- core_stall  out  1  core must hold its state this cycle
- init_done  out  1  high once clearing has completed
- dbg_req  in  1  debug access request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read (held with dbg_req)
- dbg_addr  in  5  debug register address
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  registered read data, valid while dbg_ack is high, then held
- rf_rs, rf_rt, rf_rd  out  5 each  to register file
- rf_data_in  out  32  to register file Data_In
- rf_regwrite  out  1  to register file RegWrite
- rf_rdata1  in  32  register file Rdata1

## Operation
- States: INIT, RUN, DBG.
- INIT:
  - 5-bit init_cnt drives rf_rd.
  - rf_data_in = INIT_VALUE; rf_regwrite = 1, except address 0 when ZERO_PROTECT=1, which is skipped.
  - core_stall = 1 and init_done = 0.
  - Debug requests are not granted.
  - When init_cnt = 31, go to RUN.
- RUN:
  - rf_rs/rf_rt/rf_rd/rf_data_in pass through from the core.
  - rf_regwrite = core_we, masked when ZERO_PROTECT=1 and core_rd = 0.
  - core_stall = 0.
- Grant, evaluated in RUN: dbg_req & ~dbg_ack & (~core_we | wait_cnt == DBG_MAX_WAIT).
  - On grant: next state is DBG and wait_cnt is cleared.
  - Otherwise, while dbg_req is pending: wait_cnt increments, saturating at DBG_MAX_WAIT.
  - When dbg_req is low: wait_cnt is cleared.
- DBG (exactly one cycle):
  - core_stall = 1; core_we is ignored.
  - rf_rs = dbg_addr.
  - If dbg_we: rf_rd = dbg_addr, rf_data_in = dbg_wdata, rf_regwrite = 1 (subject to ZERO_PROTECT).
  - Otherwise rf_regwrite = 0.
  - dbg_rdata <= rf_rdata1 at the closing edge (the value before this cycle's write).
  - Next state is RUN, with dbg_ack = 1 registered for that cycle.
- A debug write to address 0 with ZERO_PROTECT=1 is still acknowledged and performs no write.
- Whenever rst_n is low, rf_regwrite is forced to 0 combinationally.

## Timing
- Reset values: state INIT, init_cnt 0, wait_cnt 0, core_stall 1, init_done 0, dbg_ack 0, dbg_rdata 0.
- INIT lasts exactly 32 cycles after rst_n deasserts. init_done rises and core_stall falls in the 33rd cycle.
- Debug latency: grant cycle (RUN) -> DBG -> ack cycle. With the core idle this is 2 cycles from dbg_req sampled high to dbg_ack.
- Worst-case debug latency: DBG_MAX_WAIT + 2 cycles.
- The core loses exactly 1 cycle per debug access.
- No grant in the ack cycle, even if dbg_req is still high. This prevents a double access; the requester drops dbg_req on seeing dbg_ack.
- A core write in the grant cycle completes normally. The DBG write lands one cycle later, so the debug value wins for the same address.
- rst_n asserted mid-INIT or mid-DBG:
  - The state machine returns to INIT immediately; no ack is issued.
  - Clearing restarts from address 0 after release.

## Test plan
- Reset release with INIT_VALUE=32'hA5A5A5A5 and ZERO_PROTECT=1 -> writes to addresses 1..31 over 32 cycles, none to address 0; init_done high at cycle 33.
- In RUN, core write rd=5, data 32'h1234, core_we=1 -> rf_regwrite high with rf_rd=5; core write to rd=0 -> rf_regwrite low.
- Core idle, debug write addr 7 data 32'hDEAD_BEEF, then debug read addr 7:
  - each access gives dbg_ack 2 cycles after dbg_req;
  - the read returns 32'hDEADBEEF;
  - core_stall is high for 1 cycle per access.
- core_we held high continuously with dbg_req high, DBG_MAX_WAIT=4 -> forced grant after 4 wait cycles; dbg_ack at cycle 6.
- Core writes rd=9 value 1 in the grant cycle while debug writes addr 9 value 2 -> register 9 = 2; dbg_req held through the ack cycle -> exactly one access.
- rst_n pulsed low during DBG -> no dbg_ack, rf_regwrite 0 while low, INIT restarts from address 0.
